and4_sweep_gen: RTL and testbench

- Upstream stimulus stage for the 4-input AND block.
- Drives in1..in4 through all 16 input combinations.
  - in1 toggles every step; in2 every 2 steps; in3 every 4; in4 every 8 (binary count, in1 = LSB).
- Samples the AND block's output back and checks it against the expected AND of the driven pattern, delayed by the block latency.
- Provides single-sweep and continuous modes, abort, and a sticky error with a mismatch count.

---
 rtl/and4_pkg.sv | 19 +
 rtl/and4_prescaler.sv | 37 +++
 rtl/and4_sweep_gen.sv | 145 ++++++++++++++
 tb/tb_and4_sweep_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/and4_pkg.sv
// rtl/and4_pkg.sv - shared types and helpers for the and4 sweep generator
// Purpose : pattern width, FSM state encoding and the expected-value function.
// Ports   : none (package).
package and4_pkg;

    localparam int PATTERN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expected output of an ideal 4-input AND for a given stimulus pattern.
    function automatic logic and_reduce4(input logic [PATTERN_W-1:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/and4_prescaler.sv
// rtl/and4_prescaler.sv - step prescaler producing one tick every PRESCALE enabled cycles
// Purpose : counts 0..PRESCALE-1 while en is high; tick marks the terminal count.
// Ports   : clk, rst (async, active-high), clr (synchronous clear, wins over en),
//           en (count enable), tick (high during the terminal-count cycle).
module and4_prescaler #(
    parameter int PRESCALE = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] TERM = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == TERM) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // With PRESCALE=1 the counter never leaves 0, so tick fires every enabled cycle.
    assign tick = en && !clr && (cnt == TERM);

endmodule

// File: rtl/and4_sweep_gen.sv
// rtl/and4_sweep_gen.sv - sweeps a 4-input AND block through all 16 patterns and checks its output
// Purpose : drives in1..in4 as a binary count (in1 = LSB), compares out1_sense against the
//           AND of the pattern delayed by LAT cycles, reports sticky err and a saturating count.
// Ports   : clk, rst (async, active-high), start, stop, continuous, out1_sense (inputs);
//           in1..in4, busy, done, err, mismatch_cnt[CNT_W-1:0] (registered outputs).
module and4_sweep_gen
    import and4_pkg::*;
#(
    parameter int PRESCALE = 200,
    parameter int LAT      = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             continuous,
    output logic             in1,
    output logic             in2,
    output logic             in3,
    output logic             in4,
    input  logic             out1_sense,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [2:0] LAT_V = 3'(LAT);

    state_t                 state, state_nx;
    logic [PATTERN_W-1:0]   pattern, pattern_nx;
    logic [2:0]             lat_cnt, lat_nx;
    logic                   check_en, check_en_nx;
    logic                   cont_q;
    logic                   start_acc;
    logic                   tick;
    logic                   expected;

    and4_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != ST_RUN),
        .en   (state == ST_RUN),
        .tick (tick)
    );

    always_comb begin
        state_nx   = state;
        pattern_nx = pattern;
        lat_nx     = lat_cnt;
        start_acc  = 1'b0;
        case (state)
            ST_IDLE: begin
                pattern_nx = '0;
                if (start && !stop) begin
                    state_nx  = ST_RUN;
                    lat_nx    = '0;
                    start_acc = 1'b1;
                end
            end
            ST_RUN: begin
                if (lat_cnt != LAT_V) begin
                    lat_nx = lat_cnt + 3'd1;
                end
                if (stop) begin
                    state_nx   = ST_IDLE;
                    pattern_nx = '0;
                end else if (tick) begin
                    if (pattern == 4'hF && !cont_q) begin
                        state_nx = ST_DONE;
                    end else begin
                        pattern_nx = pattern + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nx   = ST_IDLE;
                pattern_nx = '0;
            end
            default: begin
                state_nx   = ST_IDLE;
                pattern_nx = '0;
            end
        endcase
        // Checking starts once the delay line holds values from inside this run.
        check_en_nx = (state_nx == ST_RUN) && (lat_nx == LAT_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            pattern      <= '0;
            lat_cnt      <= '0;
            check_en     <= 1'b0;
            cont_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state    <= state_nx;
            pattern  <= pattern_nx;
            lat_cnt  <= lat_nx;
            check_en <= check_en_nx;
            busy     <= (state_nx == ST_RUN);
            done     <= (state_nx == ST_DONE);
            if (start_acc) begin
                cont_q       <= continuous;
                err          <= 1'b0;
                mismatch_cnt <= '0;
            end else if (check_en && (out1_sense != expected)) begin
                err <= 1'b1;
                if (mismatch_cnt != {CNT_W{1'b1}}) begin
                    mismatch_cnt <= mismatch_cnt + 1'b1;
                end
            end
        end
    end

    generate
        if (LAT == 0) begin : g_no_dly
            assign expected = and_reduce4(pattern);
        end else begin : g_dly
            logic [LAT-1:0] sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr[0] <= and_reduce4(pattern);
                    for (int i = 1; i < LAT; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end
            assign expected = sr[LAT-1];
        end
    endgenerate

    assign in1 = pattern[0];
    assign in2 = pattern[1];
    assign in3 = pattern[2];
    assign in4 = pattern[3];

endmodule

// File: tb/tb_and4_sweep_gen.sv
// tb/tb_and4_sweep_gen.sv - randomized self-checking bench for and4_sweep_gen
module tb_and4_sweep_gen;

    localparam int P = 4;
    localparam int L = 1;

    logic clk = 1'b0;
    logic rst, start, stop, continuous, out1_sense;
    logic in1, in2, in3, in4, busy, done, err;
    logic [7:0] mismatch_cnt;
    logic s_in1, s_in2, s_in3, s_in4, s_busy, s_done, s_err;
    logic [1:0] s_mismatch_cnt;

    always #5 clk = ~clk;

    and4_sweep_gen #(.PRESCALE(P), .LAT(L), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4), .out1_sense(out1_sense),
        .busy(busy), .done(done), .err(err), .mismatch_cnt(mismatch_cnt)
    );

    and4_sweep_gen #(.PRESCALE(P), .LAT(L), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
        .in1(s_in1), .in2(s_in2), .in3(s_in3), .in4(s_in4), .out1_sense(out1_sense),
        .busy(s_busy), .done(s_done), .err(s_err), .mismatch_cnt(s_mismatch_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a run is a cycle index k; the pattern shown at k is (k/P) mod 16.
    int m_run, m_k, m_cont, m_done, m_err, m_raw;
    int prev_pat;
    int mode;
    int busy_seen, done_seen;

    function automatic int m_pattern();
        if (m_run != 0) return (m_k / P) % 16;
        if (m_done != 0) return 15;
        return 0;
    endfunction

    function automatic int exp_and(input int k);
        return (((k - L) / P) % 16 == 15) ? 1 : 0;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_k = 0; m_cont = 0; m_done = 0; m_err = 0; m_raw = 0;
        prev_pat = 0;
    endtask

    task automatic model_clock();
        if (m_done != 0) begin
            m_done = 0;
        end else if (m_run == 0) begin
            if (start && !stop) begin
                m_run = 1; m_k = 0; m_cont = int'(continuous); m_err = 0; m_raw = 0;
            end
        end else begin
            if (m_k >= L && int'(out1_sense) != exp_and(m_k)) begin
                m_err = 1;
                m_raw++;
            end
            if (stop) begin
                m_run = 0;
            end else if (m_cont == 0 && m_k == 16 * P - 1) begin
                m_run  = 0;
                m_done = 1;
            end else begin
                m_k++;
            end
        end
    endtask

    task automatic compare_all();
        check("pattern", {in4, in3, in2, in1}, m_pattern());
        check("busy", busy, m_run);
        check("done", done, m_done);
        check("err", err, m_err);
        check("mismatch_cnt", mismatch_cnt, sat(m_raw, 255));
        check("sat_pattern", {s_in4, s_in3, s_in2, s_in1}, m_pattern());
        check("sat_err", s_err, m_err);
        check("sat_mismatch_cnt", s_mismatch_cnt, sat(m_raw, 3));
    endtask

    task automatic step();
        int cur;
        cur = m_pattern();
        case (mode)
            0:       out1_sense = (prev_pat == 15);
            1:       out1_sense = 1'b0;
            2:       out1_sense = 1'b1;
            default: out1_sense = 1'($urandom_range(0, 1));
        endcase
        model_clock();
        prev_pat = cur;
        @(posedge clk);
        #1;
        compare_all();
        if (busy) busy_seen++;
        if (done) done_seen++;
    endtask

    task automatic single_sweep(input int m);
        mode = m;
        start = 1'b1; continuous = 1'b0;
        busy_seen = 0; done_seen = 0;
        step();
        start = 1'b0;
        repeat (69) step();
        check("sweep_busy_cycles", busy_seen, 16 * P);
        check("sweep_done_pulses", done_seen, 1);
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; out1_sense = 1'b0;
        mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Ideal feedback, then stuck-at-0, then stuck-at-1 sense.
        single_sweep(0);
        single_sweep(1);
        single_sweep(2);
        check("sat_cnt_final", s_mismatch_cnt, 3);
        check("sat_err_final", s_err, 1);

        // Continuous mode: wraps past 15 without done, stopped at run cycle 100.
        mode = 0;
        start = 1'b1; continuous = 1'b1;
        busy_seen = 0; done_seen = 0;
        step();
        start = 1'b0;
        repeat (100) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("cont_busy_after_stop", busy, 0);
        repeat (3) step();
        check("cont_done_pulses", done_seen, 0);

        // Start and stop together in IDLE: stop wins.
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("start_stop_busy", busy, 0);
        step();

        // Start while busy is ignored; asynchronous reset mid-sweep.
        mode = 3;
        start = 1'b1; continuous = 1'b0;
        step();
        start = 1'b0;
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        async_reset();
        check("rst_err", err, 0);
        check("rst_cnt", mismatch_cnt, 0);

        // Random start/stop/continuous/sense traffic.
        repeat (400) begin
            start      = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            continuous = 1'($urandom_range(0, 1));
            step();
        end
        start = 1'b0; stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
